// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_active;
  logic                 pkt_truncated;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, grant_active, pkt_truncated
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, grant_active, pkt_truncated
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter in front of a shared uart_tx
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MAX_PKT = 64
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_PKT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 grant_active_q, grant_active_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 pkt_trunc_q, pkt_trunc_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic                 retry_q, retry_d;
  logic                 hit;
  logic [ID_W-1:0]      winner;
  logic [ID_W:0]        cand;
  logic [7:0]           req_byte [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_byte[i] = bus.req_data[8*i +: 8];
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.grant_active  = grant_active_q;
  assign bus.pkt_truncated = pkt_trunc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      grant_active_q <= 1'b0;
      req_ready_q    <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
      byte_cnt_q     <= '0;
      pkt_trunc_q    <= 1'b0;
      wait_cnt_q     <= '0;
      retry_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_active_q <= grant_active_d;
      req_ready_q    <= req_ready_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      byte_cnt_q     <= byte_cnt_d;
      pkt_trunc_q    <= pkt_trunc_d;
      wait_cnt_q     <= wait_cnt_d;
      retry_q        <= retry_d;
    end
  end

  // Scan from the highest offset down so the lowest offset from rr_ptr is the last writer.
  always_comb begin
    hit    = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        hit    = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    grant_active_d = grant_active_q;
    req_ready_d    = '0;
    tx_start_d     = 1'b0;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    byte_cnt_d     = byte_cnt_q;
    pkt_trunc_d    = pkt_trunc_q;
    wait_cnt_d     = wait_cnt_q;
    retry_d        = retry_q;

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          grant_id_d     = winner;
          grant_active_d = 1'b1;
          retry_d        = 1'b0;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        // A retry resends the already-consumed byte without touching the requester.
        if (retry_q) begin
          if (!bus.tx_busy) begin
            tx_start_d = 1'b1;
            wait_cnt_d = '0;
            retry_d    = 1'b0;
            state_d    = WAIT_BUSY;
          end
        end else if (bus.req_valid[grant_id_q] && !bus.tx_busy) begin
          tx_data_d   = req_byte[grant_id_q];
          req_ready_d = NUM_REQ'(1) << grant_id_q;
          tx_start_d  = 1'b1;
          last_d      = bus.req_last[grant_id_q];
          if (byte_cnt_q != CNT_W'(MAX_PKT)) byte_cnt_d = byte_cnt_q + 1'b1;
          wait_cnt_d  = '0;
          state_d     = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (wait_cnt_q == 2'd3) begin
          retry_d = 1'b1;
          state_d = ISSUE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q || byte_cnt_q == CNT_W'(MAX_PKT)) begin
            grant_active_d = 1'b0;
            byte_cnt_d     = '0;
            rr_ptr_d       = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            if (!last_q) pkt_trunc_d = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .ID_W(2)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(2), .MAX_PKT(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int frame_len = 10;
  bit ack_en    = 1'b1;
  int bcnt      = 0;

  logic [8:0]   rq [N][$];
  logic [9:0]   start_log [$];
  int           start_cyc [$];
  logic [N-1:0] ready_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // uart_tx stand-in: busy for frame_len cycles after an acknowledged start
  always @(posedge clk or posedge rst) begin
    if (rst) bcnt <= 0;
    else if (bus.tx_start && ack_en) bcnt <= frame_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign bus.tx_busy = (bcnt != 0);

  // Requesters: each presents the head of its queue and pops it on req_ready
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && bus.req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        bus.req_valid[i]        = 1'b1;
        bus.req_data[8*i +: 8]  = rq[i][0][7:0];
        bus.req_last[i]         = rq[i][0][8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[8*i +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.tx_start) begin
        start_log.push_back({bus.grant_id, bus.tx_data});
        start_cyc.push_back(cyc);
      end
      if (bus.req_ready != '0) begin
        ready_log.push_back(bus.req_ready);
        check("ready_is_owner_onehot", 32'(bus.req_ready), 32'(1) << bus.grant_id);
        check("ready_with_start", 32'(bus.tx_start), 32'd1);
        check("ready_not_busy", 32'(bus.tx_busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic bit idle_now();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
    return e && !bus.grant_active && !bus.tx_busy;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    do begin tick(); k++; end while (!idle_now() && k < budget);
    check({tag, "_idle"}, 32'(idle_now()), 32'd1);
  endtask

  task automatic wait_starts(input string tag, input int n, input int budget);
    int k = 0;
    while (start_log.size() < n && k < budget) begin tick(); k++; end
    check({tag, "_starts_seen"}, 32'(start_log.size() >= n), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] id, input int budget);
    int k = 0;
    while (!(bus.grant_active && bus.grant_id == id) && k < budget) begin tick(); k++; end
    check({tag, "_grant"}, {30'd0, bus.grant_id}, {30'd0, id});
  endtask

  task automatic clear_logs();
    start_log.delete();
    start_cyc.delete();
    ready_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) rq[i].delete();
    clear_logs();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int k;
    int n3;

    // Reset values
    tick();
    tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_grant_active", 32'(bus.grant_active), 32'd0);
    check("rst_pkt_truncated", 32'(bus.pkt_truncated), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_no_grant", 32'(bus.grant_active), 32'd0);

    // Single request from requester 1
    frame_len = 10;
    @(posedge clk);
    #1;
    rq[1].push_back({1'b1, 8'h41});
    @(negedge clk);
    k = 0;
    while (!bus.tx_start && k < 20) begin @(negedge clk); k++; end
    check("t1_latency", k, 32'd2);
    check("t1_tx_data", 32'(bus.tx_data), 32'h41);
    check("t1_grant_id", 32'(bus.grant_id), 32'd1);
    check("t1_req_ready", 32'(bus.req_ready), 32'b0010);
    k = 0;
    while (!bus.tx_busy && k < 20) begin @(negedge clk); k++; end
    check("t1_busy_seen", 32'(bus.tx_busy), 32'd1);
    k = 0;
    while (bus.tx_busy && k < 30) begin @(negedge clk); k++; end
    check("t1_busy_fell", 32'(bus.tx_busy), 32'd0);
    check("t1_active_at_busy_fall", 32'(bus.grant_active), 32'd1);
    @(negedge clk);
    check("t1_active_released", 32'(bus.grant_active), 32'd0);
    tick();
    check("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd2);
    check("t1_start_count", start_log.size(), 32'd1);
    check("t1_start0", 32'(start_log[0]), 32'h141);
    check("t1_ready_count", ready_log.size(), 32'd1);

    // Packet hold: requester 0 keeps the line while requester 2 waits
    clear_logs();
    frame_len = 3;
    rq[0].push_back({1'b0, 8'h10});
    rq[0].push_back({1'b0, 8'h11});
    rq[0].push_back({1'b1, 8'h12});
    wait_grant("t2", 2'd0, 20);
    rq[2].push_back({1'b1, 8'h20});
    wait_idle("t2", 300);
    check("t2_start_count", start_log.size(), 32'd4);
    check("t2_start0", 32'(start_log[0]), 32'h010);
    check("t2_start1", 32'(start_log[1]), 32'h011);
    check("t2_start2", 32'(start_log[2]), 32'h012);
    check("t2_start3", 32'(start_log[3]), 32'h220);

    // Round-robin fairness from rr_ptr=0
    do_reset();
    rq[0].push_back({1'b1, 8'hA0});
    rq[0].push_back({1'b1, 8'hA4});
    rq[1].push_back({1'b1, 8'hA1});
    rq[2].push_back({1'b1, 8'hA2});
    rq[3].push_back({1'b1, 8'hA3});
    wait_idle("t3", 300);
    check("t3_start_count", start_log.size(), 32'd5);
    check("t3_start0", 32'(start_log[0]), 32'h0A0);
    check("t3_start1", 32'(start_log[1]), 32'h1A1);
    check("t3_start2", 32'(start_log[2]), 32'h2A2);
    check("t3_start3", 32'(start_log[3]), 32'h3A3);
    check("t3_start4", 32'(start_log[4]), 32'h0A4);
    check("t3_ready0", 32'(ready_log[0]), 32'b0001);
    check("t3_ready1", 32'(ready_log[1]), 32'b0010);
    check("t3_ready2", 32'(ready_log[2]), 32'b0100);
    check("t3_ready3", 32'(ready_log[3]), 32'b1000);
    check("t3_ready4", 32'(ready_log[4]), 32'b0001);

    // Truncation: 70 bytes with no last from requester 3
    clear_logs();
    frame_len = 2;
    for (int i = 0; i < 70; i++) rq[3].push_back({1'b0, 8'(i)});
    wait_grant("t4", 2'd3, 20);
    rq[0].push_back({1'b1, 8'h55});
    wait_starts("t4", 65, 2000);
    n3 = 0;
    for (int i = 0; i < 65; i++) if (start_log[i][9:8] == 2'd3) n3++;
    check("t4_starts_from_3", n3, 32'd64);
    check("t4_first", 32'(start_log[0]), 32'h300);
    check("t4_64th", 32'(start_log[63]), 32'h33F);
    check("t4_after_release", 32'(start_log[64]), 32'h055);
    check("t4_pkt_truncated", 32'(bus.pkt_truncated), 32'd1);
    check("t4_ready_count", ready_log.size(), 32'd65);

    // Reset in WAIT_DONE while requester 3 resends its leftover bytes
    frame_len = 10;
    k = 0;
    while (!(bus.grant_active && bus.grant_id == 2'd3 && bus.tx_busy) && k < 200) begin tick(); k++; end
    check("t6_owner3_busy", 32'(bus.grant_active && bus.grant_id == 2'd3 && bus.tx_busy), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_req_ready", 32'(bus.req_ready), 32'd0);
    check("t6_tx_start", 32'(bus.tx_start), 32'd0);
    check("t6_tx_data", 32'(bus.tx_data), 32'd0);
    check("t6_grant_id", 32'(bus.grant_id), 32'd0);
    check("t6_grant_active", 32'(bus.grant_active), 32'd0);
    check("t6_pkt_truncated", 32'(bus.pkt_truncated), 32'd0);
    for (int i = 0; i < N; i++) rq[i].delete();
    clear_logs();
    rq[1].push_back({1'b1, 8'h61});
    rq[2].push_back({1'b1, 8'h62});
    rq[3].push_back({1'b1, 8'h63});
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    wait_idle("t6", 300);
    check("t6_start_count", start_log.size(), 32'd3);
    check("t6_first_grant", 32'(start_log[0]), 32'h161);
    check("t6_second", 32'(start_log[1]), 32'h262);
    check("t6_third", 32'(start_log[2]), 32'h363);

    // Missing busy acknowledge
    clear_logs();
    frame_len = 4;
    ack_en = 1'b0;
    rq[2].push_back({1'b1, 8'h77});
    wait_starts("t5", 3, 100);
    ack_en = 1'b1;
    wait_idle("t5", 100);
    check("t5_start_count", start_log.size(), 32'd3);
    check("t5_start0", 32'(start_log[0]), 32'h277);
    check("t5_start1", 32'(start_log[1]), 32'h277);
    check("t5_start2", 32'(start_log[2]), 32'h277);
    check("t5_gap1", start_cyc[1] - start_cyc[0], 32'd5);
    check("t5_gap2", start_cyc[2] - start_cyc[1], 32'd5);
    check("t5_ready_count", ready_log.size(), 32'd1);
    check("t5_ready0", 32'(ready_log[0]), 32'b0100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end
endmodule
